// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// Build option: define APPROX_EN to honour per-quadrant truncation (MODE).
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Q0   = 3'd1,
    Q1   = 3'd2,
    Q2   = 3'd3,
    Q3   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Left shift applied to each quadrant product before accumulation
  localparam logic [3:0] SHIFT_Q0 = 4'd0;  // AL*BL
  localparam logic [3:0] SHIFT_Q1 = 4'd4;  // AL*BH
  localparam logic [3:0] SHIFT_Q2 = 4'd4;  // AH*BL
  localparam logic [3:0] SHIFT_Q3 = 4'd8;  // AH*BH

  // Approximate quadrant drops the two LSBs of the 4x4 product
  localparam logic [7:0] TRUNC_MASK = 8'hFC;

endpackage

// File: rtl/quad_mul_4x4.sv
// Combinational 4x4 partial-product multiplier, optionally truncated.
// Build option: APPROX_EN enables the truncated path; otherwise always exact.
module quad_mul_4x4
  import mult_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       approx,
  output logic [7:0] pp
);

  logic [7:0] full;

  assign full = {4'd0, a} * {4'd0, b};

`ifdef APPROX_EN
  assign pp = approx ? (full & TRUNC_MASK) : full;
`else
  logic unused_approx;
  assign unused_approx = approx;
  assign pp = full;
`endif

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier: one shared 4x4 multiplier walks the four
// quadrants over four cycles, accumulating into a 16-bit result.
// Build option: APPROX_EN keeps a MODE register selecting truncated quadrants;
// without it MODE is ignored and R = A*B.
module mult_8x8_seq_ctrl
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [3:0]  MODE,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy
);

  state_t      state, state_nx;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc;
  logic [3:0]  qa, qb, qshift;
  logic [1:0]  qsel;
  logic        qen, qapprox, accept;
  logic [7:0]  pp;
  logic [15:0] pp_sh;

`ifdef APPROX_EN
  logic [3:0] mode_q;
  assign qapprox = mode_q[qsel];
`else
  logic [3:0] unused_mode;
  logic [1:0] unused_qsel;
  assign unused_mode = MODE;
  assign unused_qsel = qsel;
  assign qapprox     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, handshake outputs and quadrant operand selection
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    qen       = 1'b0;
    qsel      = 2'd0;
    qa        = a_q[3:0];
    qb        = b_q[3:0];
    qshift    = SHIFT_Q0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = Q0;
      end
      Q0: begin
        qen      = 1'b1;
        state_nx = Q1;
      end
      Q1: begin
        qen      = 1'b1;
        qsel     = 2'd1;
        qb       = b_q[7:4];
        qshift   = SHIFT_Q1;
        state_nx = Q2;
      end
      Q2: begin
        qen      = 1'b1;
        qsel     = 2'd2;
        qa       = a_q[7:4];
        qshift   = SHIFT_Q2;
        state_nx = Q3;
      end
      Q3: begin
        qen      = 1'b1;
        qsel     = 2'd3;
        qa       = a_q[7:4];
        qb       = b_q[7:4];
        qshift   = SHIFT_Q3;
        state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  quad_mul_4x4 u_qmul (
    .a      (qa),
    .b      (qb),
    .approx (qapprox),
    .pp     (pp)
  );

  assign pp_sh  = {8'd0, pp} << qshift;
  assign accept = in_valid & in_ready;
  assign busy   = (state != IDLE);
  assign R      = acc;

  // Operand capture at accept, then one quadrant accumulated per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
`ifdef APPROX_EN
      mode_q <= '0;
`endif
    end else if (accept) begin
      a_q <= A;
      b_q <= B;
      acc <= '0;
`ifdef APPROX_EN
      mode_q <= MODE;
`endif
    end else if (qen) begin
      acc <= acc + pp_sh;
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Self-checking bench for mult_8x8_seq_ctrl: cycle-level handshake model,
// directed literal cases and randomized operations with backpressure,
// operand noise while busy and occasional mid-operation resets.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [3:0]  MODE = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] R;

  int n_chk  = 0;
  int n_pass = 0;

  mult_8x8_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .MODE      (MODE),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Product from the quadrant rules using plain integer arithmetic
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] m);
    int s, an, bn, p;
    bit approx_on;
`ifdef APPROX_EN
    approx_on = 1'b1;
`else
    approx_on = 1'b0;
`endif
    s = 0;
    for (int q = 0; q < 4; q++) begin
      an = (q >= 2) ? int'(a) / 16 : int'(a) % 16;
      bn = (q == 1 || q == 3) ? int'(b) / 16 : int'(b) % 16;
      p  = an * bn;
      if (approx_on && m[q]) p = p - (p % 4);
      s += p * ((q == 0) ? 1 : (q == 3) ? 256 : 16);
    end
    return s[15:0];
  endfunction

  // Behavioural handshake model: idle / computing (4 cycles) / result held
  bit          m_idle = 1'b1;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  logic [15:0] m_res  = '0;
  logic [15:0] m_r    = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_r    <= '0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle <= 1'b0;
        m_cnt  <= 0;
        m_res  <= ref_mul(A, B, MODE);
      end
    end else if (!m_done) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 3) m_done <= 1'b1;
    end else if (out_ready) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
      m_r    <= m_res;
    end
  end

  // Every cycle: DUT outputs against the model
  always @(negedge clk) begin
    check("in_ready", in_ready, m_idle);
    check("busy", busy, !m_idle);
    check("out_valid", out_valid, m_done);
    if (m_done) check("R_done", R, m_res);
    if (m_idle) check("R_idle", R, m_r);
  end

  // One full operation; called at a negedge, returns at a negedge with DUT idle
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m,
                       input int hold, input bit noise,
                       output logic [15:0] r, output int lat);
    int guard;
    A = a; B = b; MODE = m; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      if (noise) begin
        in_valid = 1'($urandom);
        A = 8'($urandom); B = 8'($urandom); MODE = 4'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    check("result_timeout", out_valid, 1'b1);
    r = R;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        A = 8'($urandom); B = 8'($urandom);
      end
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_R", R, r);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [15:0] r, r1, e;
  int lat, guard;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_R", R, 16'h0000);

    do_op(8'h12, 8'h34, 4'h0, 0, 1'b0, r, lat);
    check("exact_R", r, 16'h03A8);
    check("exact_lat", lat, 4);

    do_op(8'hFF, 8'hFF, 4'h0, 1, 1'b0, r, lat);
    check("max_R", r, 16'hFE01);

    do_op(8'hFF, 8'hFF, 4'hF, 0, 1'b0, r, lat);
`ifdef APPROX_EN
    check("approx_R", r, 16'hFCE0);
`else
    check("approx_R", r, 16'hFE01);
`endif

    do_op(8'h33, 8'h33, 4'b0001, 0, 1'b0, r, lat);
`ifdef APPROX_EN
    check("mixed_R", r, 16'h0A28);
`else
    check("mixed_R", r, 16'h0A29);
`endif

    // Backpressure with a second request held high through DONE
    A = 8'h21; B = 8'h43; MODE = 4'h0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 8'h5A; B = 8'hC3;
    guard = 0;
    while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
    check("bp_timeout", out_valid, 1'b1);
    r1 = R;
    check("bp_R1", r1, 16'h08A3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable_valid", out_valid, 1'b1);
      check("bp_stable_R", R, r1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_back_idle", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
    check("bp_R2", R, 16'h448E);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while in Q2
    A = 8'h77; B = 8'h99; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_R", R, 16'h0000);
    do_op(8'd3, 8'd5, 4'h0, 0, 1'b0, r, lat);
    check("post_rst_R", r, 16'd15);

    // Randomized operations
    for (int n = 0; n < 200; n++) begin
      logic [7:0] ra, rb;
      logic [3:0] rm;
      ra = 8'($urandom); rb = 8'($urandom); rm = 4'($urandom);
      if (n % 16 == 7) begin
        A = ra; B = rb; MODE = rm; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        e = ref_mul(ra, rb, rm);
        do_op(ra, rb, rm, $urandom_range(0, 3), 1'b1, r, lat);
        check("rand_R", r, e);
        check("rand_lat", lat, 4);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
